// File: rtl/cmd_arbiter_fifo.sv
// Command front-end: per-channel hold registers, round-robin arbitration and an ordered command FIFO.
// Optional gravity timer compiled in with `define CMD_GRAVITY_EN.
module cmd_arbiter_fifo #(
  parameter int NCH       = 4,
  parameter int CMD_W     = 4,
  parameter int DEPTH     = 16,
  parameter int LVL_W     = 4,
  parameter int BASE_TICK = 50_000_000,
  parameter int STEP_TICK = 2_000_000,
  parameter int MIN_TICK  = 5_000_000,
  parameter int CMD_DOWN  = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NCH-1:0]               ch_valid,
  input  logic [NCH*CMD_W-1:0]         ch_cmd,
  input  logic [LVL_W-1:0]             level,
  input  logic                         deq,
  output logic [CMD_W-1:0]             cmd,
  output logic                         cmd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [7:0]                   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  logic [NCH-1:0]   hold_full;
  logic [CMD_W-1:0] hold_cmd [NCH];
  logic [RW-1:0]    rr_ptr;

  logic             hold_any;
  logic [RW-1:0]    hold_idx;
  logic [RW-1:0]    rr_next;
  logic [NCH-1:0]   load, drop;
  logic [3:0]       ndrop;
  logic [8:0]       drop_sum;
  logic             can_push, push, push_hold, push_grav, pop;
  logic [CMD_W-1:0] push_cmd;
  logic             g_pend;

  // Round-robin search over full holds, starting at rr_ptr.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    int j;
    hold_any = 1'b0;
    hold_idx = '0;
    j        = 0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (!hold_any && hold_full[j]) begin
        hold_any = 1'b1;
        hold_idx = RW'(j);
      end
    end
  end

  assign rr_next = (hold_idx == RW'(NCH - 1)) ? '0 : hold_idx + RW'(1);

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NCH; i++) begin
      load[i] = ch_valid[i] && (ch_cmd[i*CMD_W +: CMD_W] != '0) && !hold_full[i];
      drop[i] = ch_valid[i] && (ch_cmd[i*CMD_W +: CMD_W] != '0) && hold_full[i];
      ndrop   = ndrop + 4'(drop[i]);
    end
  end

  assign drop_sum  = {1'b0, drop_cnt} + 9'(ndrop);
  assign pop       = enable && deq && (count != '0);
  assign can_push  = (count < CW'(DEPTH)) || deq;
  assign push_hold = enable && hold_any && can_push;
  assign push_grav = enable && !hold_any && g_pend && can_push;
  assign push      = push_hold || push_grav;
  assign push_cmd  = push_hold ? hold_cmd[hold_idx] : CMD_W'(CMD_DOWN);

  assign cmd_valid = (count != '0);
  assign cmd       = cmd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < NCH; i++) hold_cmd[i] <= '0;
    end else if (!enable) begin
      hold_full <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          hold_full[i] <= 1'b1;
          hold_cmd[i]  <= ch_cmd[i*CMD_W +: CMD_W];
        end else if (push_hold && hold_idx == RW'(i)) begin
          hold_full[i] <= 1'b0;
        end
      end
      if (push_hold) rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; cmd is gated by occupancy so stale words never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  // Drop accounting survives disable; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (enable && ndrop != '0) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

`ifdef CMD_GRAVITY_EN
  logic [31:0] g_cnt;
  logic [63:0] prod, diff, period;
  logic        g_tick;

  // Period saturates at zero before the floor so large levels never wrap.
  always_comb begin
    prod   = 64'(level) * 64'(STEP_TICK);
    diff   = (prod >= 64'(BASE_TICK)) ? 64'd0 : 64'(BASE_TICK) - prod;
    period = (diff < 64'(MIN_TICK)) ? 64'(MIN_TICK) : diff;
    g_tick = {32'd0, g_cnt} >= (period - 64'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_cnt  <= '0;
      g_pend <= 1'b0;
    end else if (!enable) begin
      g_cnt  <= '0;
      g_pend <= 1'b0;
    end else begin
      if (g_tick || (pop && cmd == CMD_W'(CMD_DOWN))) g_cnt <= '0;
      else                                            g_cnt <= g_cnt + 32'd1;
      g_pend <= g_tick || (g_pend && !push_grav);
    end
  end
`else
  logic unused_level;
  assign g_pend       = 1'b0;
  assign unused_level = ^level;
`endif

endmodule

// File: tb/tb_cmd_arbiter_fifo.sv
// Directed bench for cmd_arbiter_fifo: capture latency, round-robin order, backpressure,
// drop accounting, disable flush, async reset; gravity timing when CMD_GRAVITY_EN is defined.
module tb_cmd_arbiter_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  ch_valid = '0;
  logic [15:0] ch_cmd = '0;
  logic [3:0]  level = '0;
  logic        deq = 1'b0;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  cmd_arbiter_fifo #(
    .NCH(4), .CMD_W(4), .DEPTH(16), .LVL_W(4),
    .BASE_TICK(100), .STEP_TICK(30), .MIN_TICK(20), .CMD_DOWN(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ch_valid(ch_valid), .ch_cmd(ch_cmd), .level(level), .deq(deq),
    .cmd(cmd), .cmd_valid(cmd_valid), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v, input logic [15:0] c);
    ch_valid = v;
    ch_cmd   = c;
    step();
    ch_valid = '0;
    ch_cmd   = '0;
  endtask

  task automatic pop();
    deq = 1'b1;
    step();
    deq = 1'b0;
  endtask

  task automatic wait_count(input int target, input int max, output int n);
    n = 0;
    while (int'(count) != target && n < max) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int exp_order [4] = '{3, 4, 1, 2};

    #1 reset_n = 1'b0;
    #2;
    check("rst_cmd", int'(cmd), 0);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_drop", int'(drop_cnt), 0);
    step();
    reset_n = 1'b1;
    enable  = 1'b1;

    // Single pulse, two-cycle latency, then pop.
    pulse(4'b0010, 16'h0050);
    check("lat_t0_valid", int'(cmd_valid), 0);
    step();
    check("lat_cmd", int'(cmd), 5);
    check("lat_valid", int'(cmd_valid), 1);
    check("lat_count", int'(count), 1);
    pop();
    check("pop_cmd", int'(cmd), 0);
    check("pop_valid", int'(cmd_valid), 0);
    check("pop_count", int'(count), 0);
    pop();
    check("pop_empty_count", int'(count), 0);

    // Four simultaneous pulses with rr_ptr at 2.
    pulse(4'b1111, 16'h4321);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("rr_drain_count", int'(count), k);
    end
    for (int k = 0; k < 4; k++) begin
      check("rr_order", int'(cmd), exp_order[k]);
      pop();
    end
    check("rr_drop", int'(drop_cnt), 0);

    // Fill to DEPTH, then overflow a hold.
    enable = 1'b0;
    step();
    enable = 1'b1;
    for (int r = 0; r < 4; r++) begin
      pulse(4'b1111, 16'h4321);
      repeat (4) step();
    end
    check("full_count", int'(count), 16);
    check("full_head", int'(cmd), 1);
    pulse(4'b0001, 16'h0007);
    check("full_hold_count", int'(count), 16);
    check("full_no_ovf", int'(overflow), 0);
    pulse(4'b0001, 16'h0008);
    check("drop_ovf", int'(overflow), 1);
    check("drop_cnt", int'(drop_cnt), 1);
    pop();
    check("full_pushpop_count", int'(count), 16);
    check("full_pushpop_head", int'(cmd), 2);
    pulse(4'b0010, 16'h0000);
    check("zero_cmd_drop", int'(drop_cnt), 1);
    check("zero_cmd_count", int'(count), 16);

    // Drain to 5 and disable.
    repeat (11) pop();
    check("five_count", int'(count), 5);
    check("five_head", int'(cmd), 1);
    enable = 1'b0;
    step();
    check("dis_count", int'(count), 0);
    check("dis_valid", int'(cmd_valid), 0);
    check("dis_cmd", int'(cmd), 0);
    check("dis_drop", int'(drop_cnt), 1);
    check("dis_ovf", int'(overflow), 1);
    pulse(4'b1111, 16'h4321);
    step();
    check("dis_ign_count", int'(count), 0);
    check("dis_ign_drop", int'(drop_cnt), 1);
    enable = 1'b1;
    step();
    step();
    check("reen_count", int'(count), 0);

    // Async reset in the middle of activity.
    pulse(4'b0100, 16'h0900);
    step();
    check("pre_rst_cmd", int'(cmd), 9);
    ch_valid = 4'b1000;
    ch_cmd   = 16'h5000;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_cmd", int'(cmd), 0);
    check("arst_valid", int'(cmd_valid), 0);
    check("arst_count", int'(count), 0);
    check("arst_ovf", int'(overflow), 0);
    check("arst_drop", int'(drop_cnt), 0);
    ch_valid = '0;
    ch_cmd   = '0;
    step();
    reset_n = 1'b1;

`ifdef CMD_GRAVITY_EN
    // Level 0: period 100.
    enable = 1'b0;
    step();
    level  = 4'd0;
    enable = 1'b1;
    wait_count(1, 300, n);
    check("grav_l0_first", n, 101);
    check("grav_l0_cmd", int'(cmd), 2);
    wait_count(2, 300, n);
    check("grav_l0_period", n, 100);

    // Level 3: 100-90=10, floored to 20.
    enable = 1'b0;
    step();
    level  = 4'd3;
    enable = 1'b1;
    wait_count(1, 300, n);
    check("grav_l3_first", n, 21);
    wait_count(2, 300, n);
    check("grav_l3_period", n, 20);

    // Level 4: subtraction saturates at 0, floored to 20.
    enable = 1'b0;
    step();
    level  = 4'd4;
    enable = 1'b1;
    wait_count(1, 300, n);
    check("grav_l4_first", n, 21);

    // Level raised while g_cnt is already past the new period.
    enable = 1'b0;
    step();
    level  = 4'd0;
    enable = 1'b1;
    repeat (50) step();
    level = 4'd3;
    wait_count(1, 300, n);
    check("grav_lvl_change", n, 2);

    // Popping a user DOWN at g_cnt=60 restarts gravity.
    enable = 1'b0;
    step();
    level  = 4'd0;
    enable = 1'b1;
    pulse(4'b0001, 16'h0002);
    step();
    check("user_down_cmd", int'(cmd), 2);
    repeat (58) step();
    pop();
    check("user_down_popped", int'(count), 0);
    wait_count(1, 300, n);
    check("grav_restart", n, 101);
    check("grav_restart_cmd", int'(cmd), 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
